// File: rtl/corereset_pf_pkg.sv
// Shared defaults for the PolarFire fabric reset generator.
// Optional release hold stage is enabled with `define CORERESET_HOLD_EN.
package corereset_pf_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int HOLD_CYCLES_DEF = 8;
    localparam int HOLD_CNT_W      = 8;

endpackage

// File: rtl/corereset_pf_reset_sync_chain.sv
// N-flop reset synchronizer: asynchronous clear, enable-gated shift, synchronous release.
// The data input feeds the first stage so a low level can re-assert reset through the chain.
module reset_sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic arst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = sync_q;
        if (en) begin
            sync_d = {sync_q[N-2:0], d};
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/corereset_pf.sv
// Fabric reset generator: async-assert / sync-release FABRIC_RESET_N plus PLL power-down enable.
// Define CORERESET_HOLD_EN to add a HOLD_CYCLES release delay after the synchronizer.
module corereset_pf
    import corereset_pf_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic CLK,
    input  logic EXT_RST_N,
    input  logic PLL_LOCK,
    input  logic BANK_x_VDDI_STATUS,
    input  logic BANK_y_VDDI_STATUS,
    input  logic FPGA_POR_N,
    input  logic SS_BUSY,
    input  logic INIT_DONE,
    input  logic FF_US_RESTORE,
    output logic FABRIC_RESET_N,
    output logic PLL_POWERDOWN_B
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_sync
        $error("corereset_pf: SYNC_STAGES out of range 2..8");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("corereset_pf: HOLD_CYCLES out of range 1..255");
    end

    logic supply_ok;
    logic arst_n;
    logic en;
    logic sync_out;

    assign supply_ok       = FPGA_POR_N & BANK_x_VDDI_STATUS & BANK_y_VDDI_STATUS;
    assign PLL_POWERDOWN_B = supply_ok;
    assign arst_n          = supply_ok & EXT_RST_N & PLL_LOCK & INIT_DONE;
    // Flash-freeze restore freezes every flop; async clear still wins.
    assign en              = !FF_US_RESTORE;

    reset_sync_chain #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk    (CLK),
        .arst_n (arst_n),
        .en     (en),
        .d      (!SS_BUSY),
        .q      (sync_out)
    );

`ifdef CORERESET_HOLD_EN
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);

    logic [HOLD_CNT_W-1:0] cnt_q;
    logic [HOLD_CNT_W-1:0] cnt_d;
    logic                  out_q;
    logic                  out_d;

    // Counter restarts whenever the synchronizer drops; output rises on the HOLD_CYCLES-th edge.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (en) begin
            if (!sync_out) begin
                cnt_d = '0;
                out_d = 1'b0;
            end else if (!out_q) begin
                if (cnt_q == HOLD_LAST) begin
                    out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign FABRIC_RESET_N = out_q;
`else
    assign FABRIC_RESET_N = sync_out;
`endif

endmodule

// File: tb/tb_corereset_pf.sv
// Directed bench for corereset_pf with an expected-value queue and immediate assertions.
module tb_corereset_pf;

    localparam int SYNC = 2;
    localparam int HOLD = 8;
`ifdef CORERESET_HOLD_EN
    localparam int LAT      = SYNC + HOLD;
    localparam int BUSY_LAT = SYNC + 1;
`else
    localparam int LAT      = SYNC;
    localparam int BUSY_LAT = SYNC;
`endif

    logic clk = 1'b0;
    logic ext_rst_n, pll_lock, bank_x, bank_y, por_n, ss_busy, init_done, ff_restore;
    logic fabric_reset_n, pll_powerdown_b;

    logic exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    corereset_pf #(
        .SYNC_STAGES (SYNC),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .CLK                (clk),
        .EXT_RST_N          (ext_rst_n),
        .PLL_LOCK           (pll_lock),
        .BANK_x_VDDI_STATUS (bank_x),
        .BANK_y_VDDI_STATUS (bank_y),
        .FPGA_POR_N         (por_n),
        .SS_BUSY            (ss_busy),
        .INIT_DONE          (init_done),
        .FF_US_RESTORE      (ff_restore),
        .FABRIC_RESET_N     (fabric_reset_n),
        .PLL_POWERDOWN_B    (pll_powerdown_b)
    );

    task automatic expect_val(input logic v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic obs);
        logic e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: scoreboard empty, got %b", tag, obs);
        end else begin
            e = exp_q.pop_front();
            total++;
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: got %b expected %b", tag, obs, e);
            end
        end
    endtask

    task automatic set_src(input int sel, input logic v);
        case (sel)
            0: ext_rst_n = v;
            1: pll_lock  = v;
            default: init_done = v;
        endcase
    endtask

    task automatic edge_check(input string tag);
        @(posedge clk);
        #1;
        check(tag, fabric_reset_n);
    endtask

    // Release sequence: expect FABRIC_RESET_N to rise exactly on edge LAT.
    task automatic check_release(input string tag);
        for (int i = 1; i <= 16; i++) begin
            expect_val(i >= LAT);
            edge_check(tag);
        end
    endtask

    task automatic source_pulse(input int sel, input string tag);
        @(negedge clk);
        ext_rst_n = 1; pll_lock = 1; init_done = 1; bank_x = 1; bank_y = 1; por_n = 1;
        ss_busy = 1; ff_restore = 1;
        #1;
        set_src(sel, 1'b0);
        #1;
        expect_val(1'b0);
        check({tag, "_async"}, fabric_reset_n);
        ss_busy = 0; ff_restore = 0;
        #1;
        expect_val(1'b0);
        check({tag, "_unfrozen"}, fabric_reset_n);
        for (int i = 0; i < 3; i++) begin
            expect_val(1'b0);
            edge_check({tag, "_held"});
        end
        @(negedge clk);
        set_src(sel, 1'b1);
        check_release({tag, "_release"});
    endtask

    initial begin
        ext_rst_n = 0; pll_lock = 1; bank_x = 1; bank_y = 1; por_n = 1;
        ss_busy = 1; init_done = 1; ff_restore = 1;
        #1;
        expect_val(1'b0);
        check("reset_fabric", fabric_reset_n);
        expect_val(1'b1);
        check("reset_plpd", pll_powerdown_b);

        source_pulse(0, "ext_rst");
        source_pulse(1, "pll_lock");
        source_pulse(2, "init_done");

        // PLL power-down truth sweep, no clock dependence.
        @(negedge clk);
        bank_x = 1; bank_y = 0; por_n = 0;
        #1; expect_val(1'b0); check("plpd_y0_por0", pll_powerdown_b);
        bank_y = 1;
        #1; expect_val(1'b0); check("plpd_y1_por0", pll_powerdown_b);
        por_n = 1;
        #1; expect_val(1'b1); check("plpd_y1_por1", pll_powerdown_b);
        bank_y = 0;
        #1; expect_val(1'b0); check("plpd_y0_por1", pll_powerdown_b);
        bank_x = 0; bank_y = 1;
        #1; expect_val(1'b0); check("plpd_x0", pll_powerdown_b);
        bank_x = 1;
        #1; expect_val(1'b1); check("plpd_all1", pll_powerdown_b);

        // Freeze during release.
        @(negedge clk);
        ext_rst_n = 0;
        #1;
        ss_busy = 0; ff_restore = 1;
        ext_rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            expect_val(1'b0);
            edge_check("freeze_hold");
        end
        @(negedge clk);
        ff_restore = 0;
        check_release("freeze_release");

        // Async clear overrides freeze.
        @(negedge clk);
        ff_restore = 1;
        #1;
        expect_val(1'b1);
        check("frozen_released", fabric_reset_n);
        ext_rst_n = 0;
        #1;
        expect_val(1'b0);
        check("frozen_async_clr", fabric_reset_n);
        ext_rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            expect_val(1'b0);
            edge_check("frozen_after_clr");
        end
        @(negedge clk);
        ff_restore = 0;
        check_release("rerelease");

        // Busy reasserts reset through the chain.
        @(negedge clk);
        ss_busy = 1;
        for (int i = 1; i <= 4; i++) begin
            expect_val(i < BUSY_LAT);
            edge_check("busy_reassert");
        end
        @(negedge clk);
        ss_busy = 0;
        check_release("busy_release");

        // Mid-release source drop restarts the full latency.
        @(negedge clk);
        pll_lock = 0;
        #1;
        pll_lock = 1;
        expect_val(1'b0);
        edge_check("restart_e1");
        @(negedge clk);
        init_done = 0;
        #1;
        init_done = 1;
        check_release("restart_release");

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL leftover: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
